johnson_count_decoder: RTL and testbench

JOHNSON_COUNT_DECODER -- requirements
Module: johnson_count_decoder

---
 rtl/johnson_pkg.sv | 40 ++++
 rtl/johnson_to_index.sv | 25 ++
 rtl/johnson_count_decoder.sv | 167 ++++++++++++++++
 tb/tb_johnson_count_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared types and helpers for Johnson-code decoding.
//   state_e        : lock FSM states
//   johnson_legal  : 1 when a DIGITS-wide code is a legal Johnson code
//   johnson_index  : position 0..2*DIGITS-1 of a legal code
package johnson_pkg;

  localparam int unsigned MAX_DIGITS = 16;
  localparam int unsigned IDX_FULL_W = 5;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_e;

  // Legal iff the live bits contain at most one 0/1 boundary.
  function automatic logic johnson_legal(input logic [MAX_DIGITS-1:0] code,
                                         input int unsigned digits);
    int unsigned trans;
    trans = 0;
    for (int unsigned i = 0; i < MAX_DIGITS - 1; i++) begin
      if ((i + 1 < digits) && (code[i] != code[i+1])) trans = trans + 1;
    end
    return (trans <= 1);
  endfunction

  // Ones-count gives the position on the filling half; the draining half
  // (MSB already cleared) counts back down from 2*digits.
  function automatic logic [IDX_FULL_W-1:0] johnson_index(
      input logic [MAX_DIGITS-1:0] code, input int unsigned digits);
    int unsigned p;
    p = 0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      if ((i < digits) && code[i]) p = p + 1;
    end
    if (code[digits-1] || (p == 0)) return IDX_FULL_W'(p);
    return IDX_FULL_W'(2 * digits - p);
  endfunction

endpackage

// File: rtl/johnson_to_index.sv
// Combinational Johnson code legality check and position decode.
//   code    : Johnson-coded sample
//   legal_c : code is a legal Johnson code
//   index_c : decoded position (meaningful only when legal_c)
module johnson_to_index
  import johnson_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  localparam int unsigned IW = $clog2(2 * DIGITS)
) (
  input  logic [DIGITS-1:0] code,
  output logic              legal_c,
  output logic [IW-1:0]     index_c
);

  logic [MAX_DIGITS-1:0] code_ext;

  // Zero-extend to the package's fixed working width.
  always_comb begin
    code_ext = MAX_DIGITS'(code);
    legal_c  = johnson_legal(code_ext, DIGITS);
    index_c  = IW'(johnson_index(code_ext, DIGITS));
  end

endmodule

// File: rtl/johnson_count_decoder.sv
// Johnson counter position decoder with direction tracking and lock FSM.
//   clock, reset    : rising-edge clock, synchronous active-high reset
//   code_in         : Johnson-coded sample, taken when code_valid is high
//   index           : last legal decoded position
//   index_valid     : pulse, index updated from a legal sample
//   dir             : 1 forward, 0 reverse
//   locked          : lock FSM is in LOCKED
//   illegal         : pulse, sample was not a legal code
//   step_err        : pulse, legal sample jumped more than one step while locked
//   err_count       : saturating count of illegal + step_err pulses
module johnson_count_decoder
  import johnson_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned LOCK_RUN = 3,
  localparam int unsigned IW = $clog2(2 * DIGITS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DIGITS-1:0] code_in,
  input  logic              code_valid,
  output logic [IW-1:0]     index,
  output logic              index_valid,
  output logic              dir,
  output logic              locked,
  output logic              illegal,
  output logic              step_err,
  output logic [7:0]        err_count
);

  localparam int unsigned RW  = 4;
  localparam int unsigned CYC = 2 * DIGITS;
  localparam logic [IW:0]   CYC_W      = (IW + 1)'(CYC);
  localparam logic [IW:0]   STEP_FWD_W = (IW + 1)'(1);
  localparam logic [IW:0]   STEP_REV_W = (IW + 1)'(CYC - 1);
  localparam logic [RW-1:0] LOCK_RUN_W = RW'(LOCK_RUN);

  state_e          state_q, state_d;
  // index_q doubles as the last legal index used for step computation.
  logic [IW-1:0]   index_q, index_d;
  logic            dir_q, dir_d;
  logic            locked_q, locked_d;
  logic            index_valid_q, index_valid_d;
  logic            illegal_q, illegal_d;
  logic            step_err_q, step_err_d;
  logic [7:0]      err_count_q, err_count_d;
  logic [RW-1:0]   run_q, run_d;

  logic            legal_c;
  logic [IW-1:0]   new_index_c;
  logic [IW:0]     delta_c;
  logic            step_fwd_c, step_rev_c, step_zero_c;
  logic [RW-1:0]   run_next_c;
  logic            err_inc_c;

  johnson_to_index #(.DIGITS(DIGITS)) u_to_index (
    .code    (code_in),
    .legal_c (legal_c),
    .index_c (new_index_c)
  );

  // Modular step distance; biased by CYC so the subtraction never underflows.
  always_comb begin
    delta_c = (IW + 1)'({1'b0, new_index_c}) + CYC_W - (IW + 1)'({1'b0, index_q});
    if (delta_c >= CYC_W) delta_c = delta_c - CYC_W;
    step_fwd_c  = (delta_c == STEP_FWD_W);
    step_rev_c  = (delta_c == STEP_REV_W);
    step_zero_c = (delta_c == '0);
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    dir_d         = dir_q;
    run_d         = run_q;
    index_valid_d = 1'b0;
    illegal_d     = 1'b0;
    step_err_d    = 1'b0;
    err_count_d   = err_count_q;
    err_inc_c     = 1'b0;
    run_next_c    = run_q;

    if (code_valid) begin
      if (!legal_c) begin
        illegal_d = 1'b1;
        err_inc_c = 1'b1;
        state_d   = ST_UNLOCKED;
        run_d     = '0;
      end else begin
        index_valid_d = 1'b1;
        index_d       = new_index_c;
        unique case (state_q)
          ST_UNLOCKED: begin
            state_d = ST_ACQUIRE;
            run_d   = '0;
          end
          ST_ACQUIRE: begin
            if (step_fwd_c || step_rev_c) begin
              // run==0 marks the first step, which may go either way.
              if ((run_q == '0) || (step_fwd_c == dir_q)) run_next_c = run_q + RW'(1);
              else                                        run_next_c = RW'(1);
              dir_d = step_fwd_c;
              run_d = run_next_c;
              if (run_next_c >= LOCK_RUN_W) state_d = ST_LOCKED;
            end else if (!step_zero_c) begin
              run_d = '0;
            end
          end
          ST_LOCKED: begin
            if (step_fwd_c) begin
              dir_d = 1'b1;
            end else if (step_rev_c) begin
              dir_d = 1'b0;
            end else if (!step_zero_c) begin
              step_err_d = 1'b1;
              err_inc_c  = 1'b1;
              state_d    = ST_ACQUIRE;
              run_d      = '0;
            end
          end
          default: begin
            state_d = ST_UNLOCKED;
            run_d   = '0;
          end
        endcase
      end
    end

    if (err_inc_c && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    locked_d = (state_d == ST_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_UNLOCKED;
      index_q       <= '0;
      dir_q         <= 1'b1;
      locked_q      <= 1'b0;
      index_valid_q <= 1'b0;
      illegal_q     <= 1'b0;
      step_err_q    <= 1'b0;
      err_count_q   <= '0;
      run_q         <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      dir_q         <= dir_d;
      locked_q      <= locked_d;
      index_valid_q <= index_valid_d;
      illegal_q     <= illegal_d;
      step_err_q    <= step_err_d;
      err_count_q   <= err_count_d;
      run_q         <= run_d;
    end
  end

  assign index       = index_q;
  assign index_valid = index_valid_q;
  assign dir         = dir_q;
  assign locked      = locked_q;
  assign illegal     = illegal_q;
  assign step_err    = step_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_johnson_count_decoder.sv
// Scoreboard bench for johnson_count_decoder (DIGITS=4, LOCK_RUN=3).
module tb_johnson_count_decoder;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] code_in = 4'b0000;
  logic       code_valid = 1'b0;
  logic [2:0] index;
  logic       index_valid, dir, locked, illegal, step_err;
  logic [7:0] err_count;

  johnson_count_decoder #(.DIGITS(4), .LOCK_RUN(3)) dut (
    .clock       (clock),
    .reset       (reset),
    .code_in     (code_in),
    .code_valid  (code_valid),
    .index       (index),
    .index_valid (index_valid),
    .dir         (dir),
    .locked      (locked),
    .illegal     (illegal),
    .step_err    (step_err),
    .err_count   (err_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] idx;
    logic       iv;
    logic       dir;
    logic       lk;
    logic       ill;
    logic       se;
    logic [7:0] err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Pops one expectation per edge that had stimulus queued for it.
  always @(posedge clock) begin
    exp_t e;
    exp_t act;
    #1;
    if (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = {index, index_valid, dir, locked, illegal, step_err, err_count};
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs t=%0t: got idx=%0d iv=%b dir=%b lk=%b ill=%b se=%b err=%0d, expected idx=%0d iv=%b dir=%b lk=%b ill=%b se=%b err=%0d",
                 $time, act.idx, act.iv, act.dir, act.lk, act.ill, act.se, act.err,
                 e.idx, e.iv, e.dir, e.lk, e.ill, e.se, e.err);
      end
    end
  end

  // Drive one cycle of stimulus and queue the outputs expected after that edge.
  task automatic send(input int r, input int v, input logic [3:0] c,
                      input int idx, input int iv, input int d, input int lk,
                      input int ill, input int se, input int err);
    exp_t e;
    @(negedge clock);
    reset      = 1'(r);
    code_valid = 1'(v);
    code_in    = c;
    e = '{idx: 3'(idx), iv: 1'(iv), dir: 1'(d), lk: 1'(lk), ill: 1'(ill), se: 1'(se), err: 8'(err)};
    sb_q.push_back(e);
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    send(1, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 0);
    send(1, 1, 4'b1000, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_forward();
    send(0, 1, 4'b0000, 0, 1, 1, 0, 0, 0, 0);
    send(0, 1, 4'b1000, 1, 1, 1, 0, 0, 0, 0);
    send(0, 1, 4'b1100, 2, 1, 1, 0, 0, 0, 0);
    send(0, 1, 4'b1110, 3, 1, 1, 1, 0, 0, 0);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL fwd_lock: locked=%b expected 1", locked);
    end
    // code_in without code_valid must be ignored.
    send(0, 0, 4'b0101, 3, 0, 1, 1, 0, 0, 0);
  endtask

  task automatic test_wrap();
    send(0, 1, 4'b1111, 4, 1, 1, 1, 0, 0, 0);
    send(0, 1, 4'b0111, 5, 1, 1, 1, 0, 0, 0);
    send(0, 1, 4'b0011, 6, 1, 1, 1, 0, 0, 0);
    send(0, 1, 4'b0001, 7, 1, 1, 1, 0, 0, 0);
    send(0, 1, 4'b0000, 0, 1, 1, 1, 0, 0, 0);
    checks++;
    if (locked !== 1'b1 || step_err !== 1'b0 || index !== 3'd0) begin
      errors++;
      $display("FAIL wrap: locked=%b step_err=%b index=%0d expected 1 0 0", locked, step_err, index);
    end
  endtask

  task automatic test_reversal();
    send(0, 1, 4'b1000, 1, 1, 1, 1, 0, 0, 0);
    send(0, 1, 4'b1100, 2, 1, 1, 1, 0, 0, 0);
    send(0, 1, 4'b1110, 3, 1, 1, 1, 0, 0, 0);
    send(0, 1, 4'b1100, 2, 1, 0, 1, 0, 0, 0);
    checks++;
    if (dir !== 1'b0) begin
      errors++;
      $display("FAIL reversal_dir: dir=%b expected 0", dir);
    end
    send(0, 1, 4'b1000, 1, 1, 0, 1, 0, 0, 0);
  endtask

  task automatic test_skip();
    send(0, 1, 4'b1110, 3, 1, 0, 0, 0, 1, 1);
    checks++;
    if (step_err !== 1'b1 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL skip: step_err=%b err_count=%0d expected 1 1", step_err, err_count);
    end
    send(0, 0, 4'b1110, 3, 0, 0, 0, 0, 0, 1);
    // Now in ACQUIRE: three +1 steps (with a hold between) relock.
    send(0, 1, 4'b1111, 4, 1, 1, 0, 0, 0, 1);
    send(0, 1, 4'b0111, 5, 1, 1, 0, 0, 0, 1);
    send(0, 1, 4'b0111, 5, 1, 1, 0, 0, 0, 1);
    send(0, 1, 4'b0011, 6, 1, 1, 1, 0, 0, 1);
  endtask

  task automatic test_illegal();
    logic [3:0] bad [8];
    int         e;
    bad[0] = 4'b1010; bad[1] = 4'b0101; bad[2] = 4'b0100; bad[3] = 4'b1011;
    bad[4] = 4'b1101; bad[5] = 4'b0010; bad[6] = 4'b1001; bad[7] = 4'b0110;
    send(0, 1, 4'b1010, 6, 0, 1, 0, 1, 0, 2);
    for (int k = 0; k < 300; k++) begin
      e = (3 + k > 255) ? 255 : 3 + k;
      send(0, 1, bad[k % 8], 6, 0, 1, 0, 1, 0, e);
    end
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL err_sat: err_count=%0d expected 255", err_count);
    end
    send(0, 0, 4'b0000, 6, 0, 1, 0, 0, 0, 255);
    send(0, 1, 4'b0000, 0, 1, 1, 0, 0, 0, 255);
  endtask

  task automatic test_reset_with_valid();
    send(0, 1, 4'b0001, 7, 1, 0, 0, 0, 0, 255);
    send(0, 1, 4'b0011, 6, 1, 0, 0, 0, 0, 255);
    send(0, 1, 4'b0111, 5, 1, 0, 1, 0, 0, 255);
    send(1, 1, 4'b1111, 0, 0, 1, 0, 0, 0, 0);
    checks++;
    if (locked !== 1'b0 || err_count !== 8'd0 || index !== 3'd0) begin
      errors++;
      $display("FAIL reset_valid: locked=%b err_count=%0d index=%0d expected 0 0 0", locked, err_count, index);
    end
    send(0, 1, 4'b1000, 1, 1, 1, 0, 0, 0, 0);
    send(0, 1, 4'b1100, 2, 1, 1, 0, 0, 0, 0);
    send(0, 1, 4'b1110, 3, 1, 1, 0, 0, 0, 0);
    send(0, 1, 4'b1111, 4, 1, 1, 1, 0, 0, 0);
    send(0, 0, 4'b0000, 4, 0, 1, 1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_wrap();
    test_reversal();
    test_skip();
    test_illegal();
    test_reset_with_valid();
    repeat (3) @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
